// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host-side command sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

  typedef struct packed {
    logic frame_error;
    logic parity_error;
    logic clk_timeout;
    logic rqst_timeout;
  } flags_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD,
    S_SEND_ARG,
    S_WAIT_ARG,
    S_WAIT_BAT
  } seq_state_t;

  typedef enum logic [1:0] {
    SEQ_OK,
    SEQ_NACK,
    SEQ_TIMEOUT,
    SEQ_BAT_FAIL
  } seq_status_t;

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Host command/response, scan stream and ps2_controller signals of the sequencer.
interface ps2_cmd_sequencer_if;
  import ps2_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_has_arg;
  logic [7:0]  cmd_arg;
  logic        rsp_valid;
  seq_status_t rsp_status;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic        en;
  logic        tx_rqst;
  logic [7:0]  tx_data;
  logic        valid;
  logic [7:0]  rx_data;
  flags_t      flags;

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, valid, rx_data, flags,
    output cmd_ready, rsp_valid, rsp_status, scan_valid, scan_data, en, tx_rqst, tx_data
  );

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, valid, rx_data, flags,
    input  cmd_ready, rsp_valid, rsp_status, scan_valid, scan_data, en, tx_rqst, tx_data
  );

endinterface

// File: rtl/ps2_seq_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module ps2_seq_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= value;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: send opcode (+arg), await ACK, retry, report status.
// Optional BAT wait after reset command: define PS2_SEQ_BAT_WAIT_EN.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int MAX_RETRY       = 3,
  parameter int ACK_TIMEOUT_CYC = 1_000_000,
  parameter int BAT_TIMEOUT_CYC = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_cmd_sequencer_if.slave   bus
);

  localparam int TMAX = (ACK_TIMEOUT_CYC > BAT_TIMEOUT_CYC) ? ACK_TIMEOUT_CYC : BAT_TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // The tx_rqst cycle and the registered rsp_valid each take one of the budgeted cycles.
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT_CYC - 2);
  localparam logic [TW-1:0] BAT_LOAD = TW'(BAT_TIMEOUT_CYC - 1);

  seq_state_t  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, arg_q, arg_d;
  logic        has_arg_q, has_arg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        rsp_v_q, rsp_v_d;
  seq_status_t rsp_st_q, rsp_st_d;
  logic        scan_v_q, scan_v_d;
  logic [7:0]  scan_data_q, scan_data_d;
  logic        en_q;
  logic        tmr_load, tmr_expired, rx_clean;
  logic [TW-1:0] tmr_val;

  ps2_seq_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      arg_q       <= '0;
      has_arg_q   <= 1'b0;
      retry_q     <= '0;
      rsp_v_q     <= 1'b0;
      rsp_st_q    <= SEQ_OK;
      scan_v_q    <= 1'b0;
      scan_data_q <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      has_arg_q   <= has_arg_d;
      retry_q     <= retry_d;
      rsp_v_q     <= rsp_v_d;
      rsp_st_q    <= rsp_st_d;
      scan_v_q    <= scan_v_d;
      scan_data_q <= scan_data_d;
      en_q        <= 1'b1;
    end
  end

  assign rx_clean = bus.valid && (bus.flags == '0);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    has_arg_d   = has_arg_q;
    retry_d     = retry_q;
    rsp_v_d     = 1'b0;
    rsp_st_d    = rsp_st_q;
    scan_v_d    = 1'b0;
    scan_data_d = scan_data_q;
    tmr_load    = 1'b0;
    tmr_val     = ACK_LOAD;
    case (state_q)
      S_IDLE: begin
        if (rx_clean) begin
          scan_v_d    = 1'b1;
          scan_data_d = bus.rx_data;
        end
        if (bus.cmd_valid && en_q) begin
          cmd_d     = bus.cmd_byte;
          arg_d     = bus.cmd_arg;
          has_arg_d = bus.cmd_has_arg;
          retry_d   = '0;
          state_d   = S_SEND_CMD;
        end
      end
      S_SEND_CMD: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_CMD;
      end
      S_SEND_ARG: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_ARG;
      end
      S_WAIT_CMD, S_WAIT_ARG: begin
        if (bus.valid) begin
          if (!rx_clean || bus.rx_data == PS2_RESEND) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = (state_q == S_WAIT_CMD) ? S_SEND_CMD : S_SEND_ARG;
            end else begin
              rsp_v_d  = 1'b1;
              rsp_st_d = SEQ_NACK;
              state_d  = S_IDLE;
            end
          end else if (bus.rx_data == PS2_ACK) begin
            if (state_q == S_WAIT_CMD && has_arg_q) begin
              retry_d = '0;
              state_d = S_SEND_ARG;
`ifdef PS2_SEQ_BAT_WAIT_EN
            end else if (state_q == S_WAIT_CMD && cmd_q == PS2_CMD_RESET) begin
              tmr_load = 1'b1;
              tmr_val  = BAT_LOAD;
              state_d  = S_WAIT_BAT;
`endif
            end else begin
              rsp_v_d  = 1'b1;
              rsp_st_d = SEQ_OK;
              state_d  = S_IDLE;
            end
          end else begin
            scan_v_d    = 1'b1;
            scan_data_d = bus.rx_data;
          end
        end else if (tmr_expired) begin
          rsp_v_d  = 1'b1;
          rsp_st_d = SEQ_TIMEOUT;
          state_d  = S_IDLE;
        end
      end
`ifdef PS2_SEQ_BAT_WAIT_EN
      S_WAIT_BAT: begin
        if (rx_clean) begin
          if (bus.rx_data == PS2_BAT_OK || bus.rx_data == PS2_BAT_FAIL) begin
            rsp_v_d  = 1'b1;
            rsp_st_d = (bus.rx_data == PS2_BAT_OK) ? SEQ_OK : SEQ_BAT_FAIL;
            state_d  = S_IDLE;
          end else begin
            scan_v_d    = 1'b1;
            scan_data_d = bus.rx_data;
          end
        end else if (tmr_expired) begin
          rsp_v_d  = 1'b1;
          rsp_st_d = SEQ_TIMEOUT;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_SEND_CMD, S_WAIT_CMD: bus.tx_data = cmd_q;
      S_SEND_ARG, S_WAIT_ARG: bus.tx_data = arg_q;
      default:                bus.tx_data = 8'h00;
    endcase
  end

  assign bus.cmd_ready  = (state_q == S_IDLE) && en_q;
  assign bus.tx_rqst    = (state_q == S_SEND_CMD) || (state_q == S_SEND_ARG);
  assign bus.rsp_valid  = rsp_v_q;
  assign bus.rsp_status = rsp_st_q;
  assign bus.scan_valid = scan_v_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.en         = en_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer with short timeouts; BAT cases under PS2_SEQ_BAT_WAIT_EN.
module tb_ps2_cmd_sequencer;
  import ps2_pkg::*;

  localparam int ACK_T = 40;
  localparam int BAT_T = 80;
  localparam flags_t F_NONE = 4'b0000;
  localparam flags_t F_PAR  = 4'b0100;
  localparam flags_t F_RQST = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_cmd_sequencer_if bus();

  ps2_cmd_sequencer #(.MAX_RETRY(3), .ACK_TIMEOUT_CYC(ACK_T), .BAT_TIMEOUT_CYC(BAT_T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [7:0] txq[$];
  logic [7:0] scq[$];
  logic [1:0] rsq[$];

  always @(negedge clk) begin
    if (bus.tx_rqst)    txq.push_back(bus.tx_data);
    if (bus.scan_valid) scq.push_back(bus.scan_data);
    if (bus.rsp_valid)  rsq.push_back(bus.rsp_status);
  end

  task automatic clear_logs();
    txq.delete(); scq.delete(); rsq.delete();
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [7:0] b, input logic h, input logic [7:0] a);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    bus.cmd_valid = 1'b1; bus.cmd_byte = b; bus.cmd_has_arg = h; bus.cmd_arg = a;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input flags_t f);
    bus.valid = 1'b1; bus.rx_data = b; bus.flags = f;
    @(negedge clk);
    bus.valid = 1'b0; bus.flags = F_NONE;
  endtask

  task automatic dev_reply(input logic [7:0] b, input flags_t f);
    int n = 0;
    while (!bus.tx_rqst && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    drive_byte(b, f);
  endtask

  task automatic wait_rsp(output logic [1:0] st);
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin @(negedge clk); n++; end
    st = bus.rsp_valid ? bus.rsp_status : 2'bxx;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_byte = 0; bus.cmd_has_arg = 0; bus.cmd_arg = 0;
    bus.valid = 0; bus.rx_data = 0; bus.flags = F_NONE;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b want 0", bus.cmd_ready); else passed++; checks++;
    if (bus.en !== 1'b0) $display("FAIL rst_en got %b want 0", bus.en); else passed++; checks++;
    if (bus.tx_rqst !== 1'b0) $display("FAIL rst_tx_rqst got %b want 0", bus.tx_rqst); else passed++; checks++;
    if (bus.tx_data !== 8'h00) $display("FAIL rst_tx_data got %h want 00", bus.tx_data); else passed++; checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); else passed++; checks++;
    if (bus.rsp_status !== SEQ_OK) $display("FAIL rst_rsp_status got %0d want 0", bus.rsp_status); else passed++; checks++;
    if (bus.scan_valid !== 1'b0) $display("FAIL rst_scan_valid got %b want 0", bus.scan_valid); else passed++; checks++;
    if (bus.scan_data !== 8'h00) $display("FAIL rst_scan_data got %h want 00", bus.scan_data); else passed++; checks++;
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.en !== 1'b1) $display("FAIL post_rst_en got %b want 1", bus.en); else passed++; checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", bus.cmd_ready); else passed++; checks++;
  endtask

  task automatic test_two_byte();
    logic [1:0] st;
    clear_logs();
    issue_cmd(8'hED, 1'b1, 8'h02);
    if (bus.tx_rqst !== 1'b1) $display("FAIL led_rqst_lat got %b want 1", bus.tx_rqst); else passed++; checks++;
    @(negedge clk);
    if (bus.tx_rqst !== 1'b0) $display("FAIL led_rqst_pulse got %b want 0", bus.tx_rqst); else passed++; checks++;
    if (bus.tx_data !== 8'hED) $display("FAIL led_hold got %h want ED", bus.tx_data); else passed++; checks++;
    drive_byte(PS2_ACK, F_NONE);
    if (bus.tx_rqst !== 1'b1 || bus.tx_data !== 8'h02) $display("FAIL led_arg_rqst got %b/%h want 1/02", bus.tx_rqst, bus.tx_data); else passed++; checks++;
    dev_reply(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL led_status got %0d want 0", st); else passed++; checks++;
    settle();
    if (txq.size() !== 2 || txq[0] !== 8'hED || txq[1] !== 8'h02) $display("FAIL led_tx_log got n=%0d want 2 (ED,02)", txq.size()); else passed++; checks++;
    if (scq.size() !== 0 || rsq.size() !== 1) $display("FAIL led_side got scan=%0d rsp=%0d want 0/1", scq.size(), rsq.size()); else passed++; checks++;
  endtask

  task automatic test_resend();
    logic [1:0] st;
    clear_logs();
    issue_cmd(8'hF4, 1'b0, 8'h00);
    dev_reply(PS2_RESEND, F_NONE);
    dev_reply(PS2_RESEND, F_NONE);
    dev_reply(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL resend_status got %0d want 0", st); else passed++; checks++;
    settle();
    if (txq.size() !== 3 || txq[2] !== 8'hF4) $display("FAIL resend_tx_count got %0d want 3", txq.size()); else passed++; checks++;
  endtask

  task automatic test_nack();
    logic [1:0] st;
    clear_logs();
    issue_cmd(8'hF4, 1'b0, 8'h00);
    repeat (4) dev_reply(PS2_RESEND, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_NACK) $display("FAIL nack_status got %0d want 1", st); else passed++; checks++;
    repeat (10) @(negedge clk);
    #1;
    if (txq.size() !== 4) $display("FAIL nack_tx_count got %0d want 4", txq.size()); else passed++; checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL nack_idle got %b want 1", bus.cmd_ready); else passed++; checks++;
  endtask

  task automatic test_flag_retry();
    logic [1:0] st;
    clear_logs();
    issue_cmd(8'hF4, 1'b0, 8'h00);
    dev_reply(8'hFA, F_RQST);
    dev_reply(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL flag_status got %0d want 0", st); else passed++; checks++;
    settle();
    if (txq.size() !== 2 || scq.size() !== 0) $display("FAIL flag_logs got tx=%0d scan=%0d want 2/0", txq.size(), scq.size()); else passed++; checks++;
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_logs();
    issue_cmd(8'hF4, 1'b0, 8'h00);
    while (!bus.rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (n !== ACK_T) $display("FAIL timeout_cycles got %0d want %0d", n, ACK_T); else passed++; checks++;
    if (bus.rsp_status !== SEQ_TIMEOUT) $display("FAIL timeout_status got %0d want 2", bus.rsp_status); else passed++; checks++;
    settle();
    if (txq.size() !== 1) $display("FAIL timeout_no_retry got %0d want 1", txq.size()); else passed++; checks++;
  endtask

  task automatic test_ack_on_expiry();
    clear_logs();
    issue_cmd(8'hF4, 1'b0, 8'h00);
    repeat (ACK_T - 1) @(negedge clk);
    drive_byte(PS2_ACK, F_NONE);
    if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== SEQ_OK) $display("FAIL expiry_tie got %b/%0d want 1/0", bus.rsp_valid, bus.rsp_status); else passed++; checks++;
    settle();
    if (rsq.size() !== 1) $display("FAIL expiry_single got %0d want 1", rsq.size()); else passed++; checks++;
  endtask

  task automatic test_scan();
    logic [1:0] st;
    clear_logs();
    drive_byte(8'h1C, F_NONE);
    if (bus.scan_valid !== 1'b1 || bus.scan_data !== 8'h1C) $display("FAIL scan_idle got %b/%h want 1/1C", bus.scan_valid, bus.scan_data); else passed++; checks++;
    @(negedge clk);
    if (bus.scan_valid !== 1'b0) $display("FAIL scan_pulse got %b want 0", bus.scan_valid); else passed++; checks++;
    issue_cmd(8'hF4, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    drive_byte(8'h32, F_NONE);
    if (bus.scan_valid !== 1'b1 || bus.scan_data !== 8'h32) $display("FAIL scan_wait got %b/%h want 1/32", bus.scan_valid, bus.scan_data); else passed++; checks++;
    repeat (2) @(negedge clk);
    drive_byte(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL scan_cmd_status got %0d want 0", st); else passed++; checks++;
    settle();
    drive_byte(8'h55, F_PAR);
    if (bus.scan_valid !== 1'b0 || bus.scan_data !== 8'h32) $display("FAIL scan_parity got %b/%h want 0/32", bus.scan_valid, bus.scan_data); else passed++; checks++;
    settle();
    if (scq.size() !== 2 || txq.size() !== 1) $display("FAIL scan_logs got scan=%0d tx=%0d want 2/1", scq.size(), txq.size()); else passed++; checks++;
  endtask

  task automatic test_simul();
    logic [1:0] st;
    clear_logs();
    bus.cmd_valid = 1'b1; bus.cmd_byte = 8'hF3; bus.cmd_has_arg = 1'b1; bus.cmd_arg = 8'h20;
    bus.valid = 1'b1; bus.rx_data = 8'h4D; bus.flags = F_NONE;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.valid = 1'b0;
    if (bus.scan_valid !== 1'b1 || bus.scan_data !== 8'h4D) $display("FAIL simul_scan got %b/%h want 1/4D", bus.scan_valid, bus.scan_data); else passed++; checks++;
    if (bus.tx_rqst !== 1'b1 || bus.tx_data !== 8'hF3) $display("FAIL simul_tx got %b/%h want 1/F3", bus.tx_rqst, bus.tx_data); else passed++; checks++;
    dev_reply(PS2_ACK, F_NONE);
    dev_reply(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL simul_status got %0d want 0", st); else passed++; checks++;
    settle();
  endtask

  task automatic test_reset_mid();
    clear_logs();
    issue_cmd(8'hED, 1'b1, 8'h07);
    dev_reply(PS2_ACK, F_NONE);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    if (bus.cmd_ready !== 1'b0 || bus.tx_data !== 8'h00) $display("FAIL midrst_async got %b/%h want 0/00", bus.cmd_ready, bus.tx_data); else passed++; checks++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ACK_T + 10) @(negedge clk);
    #1;
    if (rsq.size() !== 0) $display("FAIL midrst_no_rsp got %0d want 0", rsq.size()); else passed++; checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL midrst_idle got %b want 1", bus.cmd_ready); else passed++; checks++;
  endtask

  task automatic test_reset_cmd();
    logic [1:0] st;
    clear_logs();
    issue_cmd(PS2_CMD_RESET, 1'b0, 8'h00);
    dev_reply(PS2_ACK, F_NONE);
`ifdef PS2_SEQ_BAT_WAIT_EN
    repeat (4) @(negedge clk);
    drive_byte(8'h5A, F_PAR);
    drive_byte(8'h11, F_NONE);
    if (bus.scan_valid !== 1'b1 || bus.scan_data !== 8'h11) $display("FAIL bat_fwd got %b/%h want 1/11", bus.scan_valid, bus.scan_data); else passed++; checks++;
    drive_byte(PS2_BAT_OK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL bat_ok got %0d want 0", st); else passed++; checks++;
    settle();
    issue_cmd(PS2_CMD_RESET, 1'b0, 8'h00);
    dev_reply(PS2_ACK, F_NONE);
    repeat (4) @(negedge clk);
    drive_byte(PS2_BAT_FAIL, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_BAT_FAIL) $display("FAIL bat_fail got %0d want 3", st); else passed++; checks++;
    settle();
    issue_cmd(PS2_CMD_RESET, 1'b0, 8'h00);
    dev_reply(PS2_ACK, F_NONE);
    wait_rsp(st);
    if (st !== SEQ_TIMEOUT) $display("FAIL bat_timeout got %0d want 2", st); else passed++; checks++;
    settle();
    clear_logs();
    issue_cmd(PS2_CMD_RESET, 1'b0, 8'h00);
    dev_reply(PS2_ACK, F_NONE);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BAT_T + 10) @(negedge clk);
    #1;
    if (rsq.size() !== 0 || bus.cmd_ready !== 1'b1) $display("FAIL bat_rst got rsp=%0d ready=%b want 0/1", rsq.size(), bus.cmd_ready); else passed++; checks++;
`else
    wait_rsp(st);
    if (st !== SEQ_OK) $display("FAIL rstcmd_status got %0d want 0", st); else passed++; checks++;
    settle();
    if (txq.size() !== 1 || txq[0] !== PS2_CMD_RESET) $display("FAIL rstcmd_tx got %0d want 1", txq.size()); else passed++; checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_resend();
    test_nack();
    test_flag_retry();
    test_timeout();
    test_ack_on_expiry();
    test_scan();
    test_simul();
    test_reset_mid();
    test_reset_cmd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Host-side command sequencer sitting between system logic and `ps2_controller`. Accepts one- or two-byte host-to-device commands (e.g. 0xED + LED mask, 0xF3 + rate, 0xFF reset), drives the controller's transmit request, waits for the device ACK, retries on RESEND or error, and reports a completion status. Device bytes that are not command responses are forwarded as scan codes, so the controller is time-shared between the command path and the receive stream.

## Interface
- `MAX_RETRY`, 3: transmit attempts per byte beyond the first before NACK.
- `ACK_TIMEOUT_CYC`, 1_000_000: cycles allowed from `tx_rqst` to a response byte (20 ms at 50 MHz).
- `BAT_TIMEOUT_CYC`, 50_000_000: cycles allowed for BAT completion after a reset ACK (1 s).

- `clk` in 1: host clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: sequencer idle, command accepted when `cmd_valid && cmd_ready`.
- `cmd_byte` in 8: command opcode.
- `cmd_has_arg` in 1: send `cmd_arg` after the opcode is ACKed.
- `cmd_arg` in 8: argument byte.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_status` out 2: `ps2_pkg::seq_status_t` (OK, NACK, TIMEOUT, BAT_FAIL).
- `scan_valid` out 1: one-cycle strobe, forwarded device byte.
- `scan_data` out 8: forwarded byte.
- `en` out 1: controller enable.
- `tx_rqst` out 1: one-cycle transmit request to controller.
- `tx_data` out 8: byte to transmit.
- `valid` in 1: controller byte/flags strobe.
- `rx_data` in 8: received byte.
- `flags` in `ps2_pkg::flags_t`: frame_error, parity_error, clk_timeout, rqst_timeout.

## Operation
- States: IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, WAIT_BAT (macro only).
- IDLE: `cmd_ready`=1. On accept, latch `cmd_byte/has_arg/arg`, clear retry count -> SEND_CMD.
- SEND_x: pulse `tx_rqst`, `tx_data` = latched byte, load timer with `ACK_TIMEOUT_CYC` -> WAIT_x.
- WAIT_x on `valid` with `flags`==0:
  - 0xFA: WAIT_CMD -> SEND_ARG if `has_arg`, else finish OK (or WAIT_BAT if opcode 0xFF, macro on); WAIT_ARG -> finish OK.
  - 0xFE: retry.
  - other: forwarded on `scan_*`, state and timer unchanged.
- WAIT_x on `valid` with any flag set (incl. `rqst_timeout`): retry, byte not forwarded.
- Retry: if count < `MAX_RETRY`, increment, return to SEND of the same byte; else finish NACK.
- Timer expiry in WAIT_x: finish TIMEOUT, no retry.
- Finish: `rsp_valid`=1 one cycle with status, -> IDLE.
- IDLE: `valid` with `flags`==0 forwards byte; with flags set, byte dropped.
- `en`: 0 in reset, 1 from first clock after reset release, never deasserted.

## Timing
- Reset values: `cmd_ready`=0 during reset (1 from first clock after release), `rsp_valid`=0, `rsp_status`=OK, `scan_valid`=0, `scan_data`=0, `en`=0, `tx_rqst`=0, `tx_data`=0.
- Accept at edge N -> `tx_rqst` high during cycle N+1 exactly one cycle; `tx_data` held until leaving WAIT_x.
- Timer counts from the `tx_rqst` cycle; expiry when it reaches 0 after `ACK_TIMEOUT_CYC` cycles.
- `valid` at edge N -> `scan_valid`/`rsp_valid` at N+1 (registered).
- `valid` on the expiry cycle: the byte wins, timeout ignored.
- `cmd_valid` and `valid` together in IDLE: byte forwarded and command accepted in the same cycle.
- `rst_n` low mid-command: immediate return to IDLE, no `rsp_valid`; pending command lost.

## Configuration
- `PS2_SEQ_BAT_WAIT_EN` defined: after ACK of opcode 0xFF, enter WAIT_BAT with `BAT_TIMEOUT_CYC`; 0xAA -> OK, 0xFC -> BAT_FAIL, expiry -> TIMEOUT, flagged bytes ignored, other bytes forwarded.
- Undefined: 0xFF handled like any other command; finishes OK on ACK; WAIT_BAT and its timer load absent.

## Structure
- `ps2_pkg` additions: `PS2_ACK`=8'hFA, `PS2_RESEND`=8'hFE, `PS2_BAT_OK`=8'hAA, `PS2_BAT_FAIL`=8'hFC, `PS2_CMD_RESET`=8'hFF, `seq_state_t`, `seq_status_t`.
- Sub-module `ps2_seq_timer`: loadable down-counter, width `$clog2` of the larger timeout, `load`/`value`/`expired`.

## Test plan
- Cmd 0xED arg 0x02; device ACKs both -> two `tx_rqst` (0xED, 0x02), `rsp_valid` with OK, no `scan_valid`.
- Cmd 0xF4; device replies 0xFE twice then 0xFA -> three `tx_rqst` of 0xF4, OK.
- Cmd 0xF4; device always 0xFE -> `MAX_RETRY`+1 = 4 requests, NACK.
- Cmd 0xF4, no device response -> `rsp_valid` with TIMEOUT exactly `ACK_TIMEOUT_CYC` cycles after `tx_rqst`.
- Scan code 0x1C arrives in IDLE and 0x32 during WAIT_CMD -> both on `scan_data`, command still completes OK; parity-error byte in IDLE -> no `scan_valid`.
- Macro on: cmd 0xFF, ACK then 0xAA -> OK; repeat with 0xFC -> BAT_FAIL; `rst_n` pulse in WAIT_BAT -> IDLE, no `rsp_valid`.
